// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch block.
package ifetch_pkg;

  localparam int          INSTR_W    = 32;
  localparam logic [31:0] PC_INC     = 32'd4;
  localparam int          OPCODE_MSB = 31;
  localparam int          OPCODE_LSB = 27;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  function automatic logic [4:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-side bus: instruction memory port, redirect request and decode handshake.
interface instr_fetch_if;
  import ifetch_pkg::*;

  logic [31:0]        imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [31:0]        out_pc;
  logic               fault;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, fault,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, fault,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/instr_fetch_buf.sv
// Two-entry fetch FIFO of {instr, pc}; flush has priority over push and pop.
module fetch_buf
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic         do_push_s;
  logic         do_pop_s;

  always_comb begin
    do_pop_s  = pop & ~flush & (count_r != 2'd0);
    do_push_s = push & ~flush & ((count_r != 2'd2) | do_pop_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) wr_ptr_r <= ~wr_ptr_r;
      if (do_pop_s)  rd_ptr_r <= ~rd_ptr_r;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage is cleared on reset so the outputs read zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, redirect handling and a 2-deep output buffer.
// Optional bounds check enabled by defining IFETCH_BOUNDS_CHECK_EN.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_WORDS = 40
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_fetch_if.master  bus
);

`ifdef IFETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);

  logic [31:0]  pc_r;
  logic         fault_r;
  logic [31:0]  target_s;
  logic         oob_s;
  logic         tgt_oob_s;
  logic         valid_s;
  logic         pop_s;
  logic         fetch_s;
  logic [1:0]   count_s;
  fetch_entry_t head_s;
  fetch_entry_t push_data_s;
  logic         unused_s;

  always_comb begin
    target_s    = {bus.redirect_pc[31:2], 2'b00};
    oob_s       = BOUNDS_EN && (pc_r >= LIMIT);
    tgt_oob_s   = BOUNDS_EN && (target_s >= LIMIT);
    valid_s     = (count_s != 2'd0);
    pop_s       = valid_s & bus.out_ready;
    // An out-of-range PC blocks the fetch in the same cycle; fault follows a cycle later.
    fetch_s     = ~bus.redirect_valid & ~fault_r & ~oob_s & ((count_s < 2'd2) | pop_s);
    push_data_s = '{instr: bus.imem_instr, pc: pc_r};
  end

  assign unused_s = ^bus.redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc_r <= target_s;
    end else if (fetch_s) begin
      pc_r <= pc_r + PC_INC;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Sticky fault; a redirect clears it unless the target is itself out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_r <= 1'b0;
    end else if (bus.redirect_valid) begin
      fault_r <= fault_r & tgt_oob_s;
    end else if (oob_s) begin
      fault_r <= 1'b1;
    end else begin
      fault_r <= fault_r;
    end
  end

  fetch_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fetch_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .flush     (bus.redirect_valid),
    .count     (count_s),
    .head      (head_s)
  );

  assign bus.imem_addr = pc_r;
  assign bus.out_valid = valid_s;
  assign bus.out_instr = head_s.instr;
  assign bus.out_pc    = head_s.pc;
  assign bus.fault     = fault_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a combinational memory model.
module tb_instr_fetch;
  import ifetch_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(32'd0), .MEM_WORDS(40)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'h5800_0000 ^ (a * 32'h0001_0001);
  endfunction

  assign bus.imem_instr = imem_word(bus.imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst_n              = 1'b0;
    bus.out_ready      = ready;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    tick();
    check_eq("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_pc",    bus.out_pc, 32'd0);
    check_eq("rst_instr", bus.out_instr, 32'd0);
    check_eq("rst_addr",  bus.imem_addr, 32'd0);
    check_eq("rst_fault", {31'd0, bus.fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Sequential stream with ready high
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("seq_valid", {31'd0, bus.out_valid}, 32'd1);
      check_eq("seq_pc", bus.out_pc, 32'(i * 4));
      check_eq("seq_instr", bus.out_instr, imem_word(32'(i * 4)));
    end

    // Back-pressure: buffer fills, PC holds, head stable
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("bp_pc", bus.out_pc, 32'd0);
      check_eq("bp_instr", bus.out_instr, 32'h5800_0000);
    end
    check_eq("bp_opcode", {27'd0, opcode_of(bus.out_instr)}, 32'd11);
    check_eq("bp_addr", bus.imem_addr, 32'd8);
    bus.out_ready = 1'b1;
    tick();
    check_eq("bp_drain1", bus.out_pc, 32'd4);
    tick();
    check_eq("bp_drain2", bus.out_pc, 32'd8);
    check_eq("bp_drain2_v", {31'd0, bus.out_valid}, 32'd1);
    tick();
    check_eq("bp_drain3", bus.out_pc, 32'd12);

    // Redirect while full: flush, aligned target
    do_reset(1'b0);
    tick();
    tick();
    check_eq("rd_full_addr", bus.imem_addr, 32'd8);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_000E;
    tick();
    check_eq("rd_valid0", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rd_addr", bus.imem_addr, 32'h0000_000C);
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    tick();
    check_eq("rd_valid1", {31'd0, bus.out_valid}, 32'd1);
    check_eq("rd_pc", bus.out_pc, 32'h0000_000C);
    check_eq("rd_instr", bus.out_instr, imem_word(32'h0000_000C));

`ifdef IFETCH_BOUNDS_CHECK_EN
    // Bounds check: stop after the last in-range word
    do_reset(1'b1);
    for (int i = 0; i < 40; i++) tick();
    check_eq("bc_last_pc", bus.out_pc, 32'd156);
    check_eq("bc_addr", bus.imem_addr, 32'd160);
    tick();
    check_eq("bc_fault", {31'd0, bus.fault}, 32'd1);
    check_eq("bc_valid0", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check_eq("bc_hold_addr", bus.imem_addr, 32'd160);
    check_eq("bc_sticky", {31'd0, bus.fault}, 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd0;
    tick();
    bus.redirect_valid = 1'b0;
    check_eq("bc_clear", {31'd0, bus.fault}, 32'd0);
    tick();
    check_eq("bc_restart", bus.out_pc, 32'd0);
`else
    // Wrap at the top of the address space; no fault
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    check_eq("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    check_eq("wr_pc_top", bus.out_pc, 32'hFFFF_FFFC);
    tick();
    check_eq("wr_pc_zero", bus.out_pc, 32'h0000_0000);
    check_eq("wr_instr", bus.out_instr, 32'h5800_0000);
    check_eq("wr_fault", {31'd0, bus.fault}, 32'd0);
    // Beyond the memory limit fetch continues
    do_reset(1'b1);
    for (int i = 0; i < 41; i++) tick();
    check_eq("nb_pc", bus.out_pc, 32'd160);
    check_eq("nb_fault", {31'd0, bus.fault}, 32'd0);
`endif

    // Asynchronous reset mid-stream with two entries buffered
    do_reset(1'b0);
    tick();
    tick();
    check_eq("ar_valid_pre", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    check_eq("ar_addr", bus.imem_addr, 32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check_eq("ar_first_pc", bus.out_pc, 32'd0);
    tick();
    check_eq("ar_second_pc", bus.out_pc, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'd0: byte address of the first fetch after reset.
REQ-002 Parameter MEM_WORDS, default 40: instruction memory depth in 32-bit words; limit address = MEM_WORDS*4.
REQ-003 clk  input  1: single clock; all state on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 imem_addr  output  32: byte address to instruction memory; equals the PC register (no combinational path from inputs).
REQ-006 imem_instr  input  32: instruction word returned combinationally by memory for imem_addr.
REQ-007 redirect_valid  input  1: branch/jump redirect request.
REQ-008 redirect_pc  input  32: redirect target byte address.
REQ-009 out_valid  output  1: out_instr/out_pc hold a fetched instruction.
REQ-010 out_ready  input  1: downstream (decode) accepts the entry this cycle.
REQ-011 out_instr  output  32: fetched instruction word.
REQ-012 out_pc  output  32: byte address the instruction came from.
REQ-013 fault  output  1: PC out of memory range (see Configuration).

Function
REQ-014 The block SHALL hold a 32-bit PC and a 2-entry FIFO of {instr, pc} pairs; the FIFO head drives out_instr/out_pc.
REQ-015 pop = out_valid & out_ready; fetch = !redirect_valid & !fault & (count<2 | pop).
REQ-016 On fetch, {imem_instr, PC} SHALL be pushed and PC SHALL become PC+4, mod 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-017 Latency: an instruction at address A appears on out_* in the cycle after PC==A; sustained throughput is 1 instruction/cycle while out_ready=1.
REQ-018 out_valid SHALL equal (count!=0); once asserted, out_instr/out_pc SHALL remain stable until popped.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; at count==2 with out_ready=0, no fetch occurs and PC holds.
REQ-020 redirect_valid SHALL take priority over all events: FIFO flushed (count=0, any pop discarded), PC <= {redirect_pc[31:2],2'b00}, no push; out_valid is 0 in the following cycle.
REQ-021 Fetch order SHALL be program order; no entry is duplicated or dropped except by redirect flush.

Reset
REQ-022 While rst_n=0: PC=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0, fault=0, immediately and asynchronously.
REQ-023 Reset asserted mid-stream SHALL discard all buffered entries; the first fetch after deassertion SHALL be from RESET_PC.

Configuration
REQ-024 Macro IFETCH_BOUNDS_CHECK_EN defined: when PC >= MEM_WORDS*4 and no redirect, fault SHALL set the next cycle and stay set (sticky), fetch stops; buffered entries still drain; only redirect to an in-range address or reset clears fault.
REQ-025 Macro undefined: no bounds check; fault tied to 0; fetch continues at any address.

Structure
REQ-026 Shared package ifetch_pkg SHALL hold INSTR_W=32, PC_INC=4, the fetch-entry struct {instr, pc}, and the opcode field position [31:27].
REQ-027 The 2-entry FIFO SHALL be a sub-module fetch_buf (push, pop, flush, count, head data); PC/fetch control stays in instr_fetch.

Verification
REQ-028 Reset release, out_ready=1, memory holding 5 words at 0..16 -> out_pc 0,4,8,12,16 on consecutive cycles starting cycle 1; first out_instr = 32'h58000000.
REQ-029 out_ready=0 for 4 cycles after reset -> count saturates at 2, PC holds at 8, out_pc stays 0 and out_instr stable; ready=1 -> 0,4,8 delivered without gap or duplicate.
REQ-030 redirect_valid=1, redirect_pc=32'h0000000E with FIFO full -> next cycle out_valid=0, imem_addr=32'h0000000C; following cycle out_pc=32'h0000000C.
REQ-031 With IFETCH_BOUNDS_CHECK_EN, MEM_WORDS=40, sequential fetch -> last out_pc=156, fault=1 when PC=160, no further pushes; redirect to 0 clears fault.
REQ-032 redirect_pc=32'hFFFFFFFC, ready=1 -> out_pc FFFFFFFC then 00000000 (wrap); without the macro fault stays 0.
REQ-033 rst_n pulsed low mid-stream with 2 entries buffered -> out_valid drops asynchronously; after release first out_pc=RESET_PC.
